alu_multicycle: RTL

Parametrised WIDTH-bit multi-cycle ALU for the datapath's execute stage. It keeps the existing function codes (AND, OR, ADD, SUB, SLT) and adds logical shifts and unsigned multiply, which are executed iteratively. A start/done handshake lets the controller stall while a long operation runs. All results and flags are registered and held until the next completion.

---
 rtl/alu_multicycle_if.sv | 26 ++
 rtl/alu_multicycle.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/alu_multicycle_if.sv
// rtl/alu_multicycle_if.sv - start/done handshake and result bus of the multi-cycle ALU
interface alu_multicycle_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [5:0]       Signal;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] out_hi;
  logic             cout;
  logic             overflow;
  logic             zero;

  modport master (
    output start, a, b, Signal,
    input  busy, done, out, out_hi, cout, overflow, zero
  );

  modport slave (
    input  start, a, b, Signal,
    output busy, done, out, out_hi, cout, overflow, zero
  );
endinterface

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - WIDTH-bit ALU with iterative shifts and shift-add unsigned multiply
module alu_multicycle #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_multicycle_if.slave bus
);
  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_SLL   = 6'd0;
  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [SW:0] CNT_ONE = (SW+1)'(1);
  localparam logic [SW:0] CNT_MUL = (SW+1)'(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, MULT, FIN} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   a_r, b_r;
  logic [5:0]         op_r;
  logic [SW:0]        cnt;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   out_r, out_hi_r;
  logic               cout_r, ovf_r, zero_r, done_r;

  // FIN only registers the finished result, so it can take a new request like IDLE
  logic ready, accept, to_shift;
  assign ready    = (state == IDLE) || (state == FIN);
  assign accept   = ready && bus.start;
  assign to_shift = ((bus.Signal == OP_SLL) || (bus.Signal == OP_SRL)) && (bus.b[SW-1:0] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE, FIN: begin
        if (bus.start) begin
          if (to_shift)                    state_n = SHIFT;
          else if (bus.Signal == OP_MULTU) state_n = MULT;
          else                             state_n = FIN;
        end else begin
          state_n = IDLE;
        end
      end
      SHIFT, MULT: if (cnt == CNT_ONE) state_n = FIN;
      default:     state_n = IDLE;
    endcase
  end

  // a_r doubles as the shift working register, b_r as the shifting multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      op_r  <= '0;
      cnt   <= '0;
      acc   <= '0;
      mcand <= '0;
    end else if (accept) begin
      a_r   <= bus.a;
      b_r   <= bus.b;
      op_r  <= bus.Signal;
      cnt   <= (bus.Signal == OP_MULTU) ? CNT_MUL : {1'b0, bus.b[SW-1:0]};
      acc   <= '0;
      mcand <= {{WIDTH{1'b0}}, bus.a};
    end else if (state == SHIFT) begin
      a_r <= (op_r == OP_SLL) ? (a_r << 1) : (a_r >> 1);
      cnt <= cnt - CNT_ONE;
    end else if (state == MULT) begin
      if (b_r[0]) acc <= acc + mcand;
      mcand <= mcand << 1;
      b_r   <= b_r >> 1;
      cnt   <= cnt - CNT_ONE;
    end
  end

  logic             sub_op, ovf_raw;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  assign sub_op  = (op_r == OP_SUB) || (op_r == OP_SLT);
  assign b_eff   = sub_op ? ~b_r : b_r;
  assign sum     = {1'b0, a_r} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_op};
  assign ovf_raw = (a_r[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_r[WIDTH-1]);

  logic [WIDTH-1:0] res, res_hi;
  logic             res_c, res_v;
  always_comb begin
    res    = '0;
    res_hi = '0;
    res_c  = 1'b0;
    res_v  = 1'b0;
    case (op_r)
      OP_AND:         res = a_r & b_r;
      OP_OR:          res = a_r | b_r;
      OP_ADD, OP_SUB: begin
        res   = sum[WIDTH-1:0];
        res_c = sum[WIDTH];
        res_v = ovf_raw;
      end
      OP_SLT:         res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf_raw};
      OP_SLL, OP_SRL: res = a_r;
      OP_MULTU: begin
        res    = acc[WIDTH-1:0];
        res_hi = acc[2*WIDTH-1:WIDTH];
      end
      default:        res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r    <= '0;
      out_hi_r <= '0;
      cout_r   <= 1'b0;
      ovf_r    <= 1'b0;
      zero_r   <= 1'b1;
      done_r   <= 1'b0;
    end else if (state == FIN) begin
      out_r    <= res;
      out_hi_r <= res_hi;
      cout_r   <= res_c;
      ovf_r    <= res_v;
      zero_r   <= (res == '0);
      done_r   <= 1'b1;
    end else begin
      done_r   <= 1'b0;
    end
  end

  assign bus.busy     = (state == SHIFT) || (state == MULT);
  assign bus.done     = done_r;
  assign bus.out      = out_r;
  assign bus.out_hi   = out_hi_r;
  assign bus.cout     = cout_r;
  assign bus.overflow = ovf_r;
  assign bus.zero     = zero_r;
endmodule
